cfa_tap_window: RTL and testbench
=================================

CFA_TAP_WINDOW -- requirements
Module: cfa_tap_window

Interface
REQ-001 SHALL have parameter LINE_W, default 640, meaning pixels per line (range 5..1023).
REQ-002 SHALL have parameter PIX_W, default 12, meaning pixel width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port pix_in, input, PIX_W bits: raster pixel, unsigned.
REQ-006 SHALL have port pix_valid, input, 1 bit: pix_in is accepted on this edge.
REQ-007 SHALL have port line_start, input, 1 bit: start-of-line marker.
REQ-008 SHALL have ports e1..e5, output, PIX_W bits each: 5-tap horizontal window; e1 oldest, e3 centre, e5 newest.
REQ-009 SHALL have port mean_1, output, PIX_W bits: rounded mean of the four non-centre taps.
REQ-010 SHALL have port out_valid, output, 1 bit: e1..e5 and mean_1 are valid this cycle.
REQ-011 SHALL have port line_err, output, 1 bit: sticky overrun flag.

Function
REQ-012 SHALL shift pix_in into a 5-deep tap register on every edge with pix_valid=1 and an accepted pixel; taps hold otherwise.
REQ-013 SHALL keep fill count fcnt (0..5, saturating) and column count col (0..LINE_W).
REQ-014 SHALL, on line_start=1 with pix_valid=1, treat that pixel as column 0: fcnt<=1, col<=1, pixel shifted in.
REQ-015 SHALL, on line_start=1 with pix_valid=0, set fcnt<=0 and col<=0 without shifting.
REQ-016 SHALL, on pix_valid=1 with line_start=0 and col=LINE_W, drop the pixel, leave taps/counters unchanged, and set line_err<=1.
REQ-017 SHALL raise a stage-1 valid when an accepted pixel makes fcnt reach or stay at 5.
REQ-018 SHALL register e1..e5, mean_1 and out_valid in stage 2, giving 2-edge latency from the accepting edge of the 5th pixel to out_valid=1.
REQ-019 SHALL compute mean_1 = (e1+e2+e4+e5+2)>>2 using a PIX_W+2-bit sum; the result never exceeds 2^PIX_W-1.
REQ-020 SHALL hold e1..e5 and mean_1 at their last values when out_valid=0.
REQ-021 SHALL assert out_valid for exactly one cycle per accepted pixel of column index >=4; there is no backpressure.
REQ-022 SHALL produce no window spanning two lines; a window emitted after line_start contains only the new line's pixels.

Reset
REQ-023 SHALL, while rst=1, force e1..e5=0, mean_1=0, out_valid=0, line_err=0, fcnt=0, col=0, taps=0, and stage-1 valid=0, independent of clk.
REQ-024 SHALL, if rst asserts mid-line, discard the partial window; after release, out_valid stays 0 until 5 new pixels are accepted.
REQ-025 SHALL clear line_err only by rst.

Structure
REQ-026 SHALL take PIX_W default, the tap count (5) and the rounding constant (2) from shared package cfa_pkg, which equ_7 also uses.
REQ-027 SHALL instantiate one sub-module, cfa_mean4 (combinational 4-input rounded mean); everything else is flat.
REQ-028 SHALL connect e1..e5 and mean_1 port-for-port to equ_7 inputs without glue logic.

Verification
REQ-029 SHALL check: line_start+pix 10, then pix 20,30,40,50 on consecutive edges -> out_valid high 2 edges after 50; e1..e5=10,20,30,40,50; mean_1=30.
REQ-030 SHALL check: continued pix 60 -> next cycle e1..e5=20..60, mean_1=40; pix 4095 x5 -> mean_1=4095, no overflow.
REQ-031 SHALL check: pixels 1,2,3 with gaps of pix_valid=0 -> taps hold; out_valid is 0 throughout; rounding check with taps 1,2,x,2,2 gives mean_1=2.
REQ-032 SHALL check: line_start after 3 pixels of line A, then 5 pixels of line B -> the first window contains only B pixels.
REQ-033 SHALL check: LINE_W=8, 9 pixels without line_start -> the 9th is dropped, line_err=1 and stays 1 after a later line_start.
REQ-034 SHALL check: rst pulse asserted between clock edges mid-line -> all outputs 0 immediately; 5 pixels are needed after release before out_valid=1.

Source files
------------

// File: rtl/cfa_pkg.sv
// Shared constants for the CFA filter front end (tap window and its consumers).
package cfa_pkg;

  // Default raster pixel width in bits.
  localparam int PIX_W_DEF = 12;

  // Number of horizontal taps in the window (e1..e5).
  localparam int TAPS = 5;

  // Rounding constant added before the divide-by-four in the neighbour mean.
  localparam int ROUND_C = 2;

  // Index of the centre tap, excluded from the neighbour mean.
  localparam int CENTRE = 2;

endpackage

// File: rtl/cfa_mean4.sv
// Combinational rounded mean of four unsigned pixels: (a+b+c+d+2)>>2.
module cfa_mean4
  import cfa_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic [PIX_W-1:0] a,
  input  logic [PIX_W-1:0] b,
  input  logic [PIX_W-1:0] c,
  input  logic [PIX_W-1:0] d,
  output logic [PIX_W-1:0] mean
);

  // Two extra bits hold four full-scale pixels plus the rounding constant,
  // so the shifted result always fits back into PIX_W bits.
  logic [PIX_W+1:0] sum;

  // Sum with rounding and divide by four.
  always_comb begin
    sum  = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d} + (PIX_W+2)'(ROUND_C);
    mean = sum[PIX_W+1:2];
  end

endmodule

// File: rtl/cfa_tap_window.sv
// 5-tap horizontal pixel window with line tracking, overrun detection and a
// rounded mean of the four non-centre taps.
//
// Handshake: pix_valid qualifies pix_in on a rising edge; there is no ready,
// the block accepts every valid pixel unless the line is already full.
// out_valid is a one-cycle strobe per emitted window with no backpressure;
// e1..e5 and mean_1 hold their last values while out_valid is low.
module cfa_tap_window
  import cfa_pkg::*;
#(
  parameter int LINE_W = 640,
  parameter int PIX_W  = PIX_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  input  logic             line_start,
  output logic [PIX_W-1:0] e1,
  output logic [PIX_W-1:0] e2,
  output logic [PIX_W-1:0] e3,
  output logic [PIX_W-1:0] e4,
  output logic [PIX_W-1:0] e5,
  output logic [PIX_W-1:0] mean_1,
  output logic             out_valid,
  output logic             line_err
);

  localparam int COL_W  = $clog2(LINE_W + 1);
  localparam int FCNT_W = $clog2(TAPS + 1);

  // Tap register, index 0 is the oldest pixel.
  logic [PIX_W-1:0]  taps [TAPS];
  logic [FCNT_W-1:0] fcnt;
  logic [COL_W-1:0]  col;

  // Window complete in taps (set on the accepting edge of the 5th pixel).
  logic              tap_full;

  // Stage 1: snapshot of a complete window.
  logic              s1_valid;
  logic [PIX_W-1:0]  s1_taps [TAPS];

  logic              accept;
  logic              drop;
  logic [FCNT_W-1:0] fcnt_nxt;
  logic [COL_W-1:0]  col_nxt;
  logic              win_done;
  logic [PIX_W-1:0]  mean_w;

  // Accept/drop decision and next fill/column counts.
  always_comb begin
    accept   = 1'b0;
    drop     = 1'b0;
    fcnt_nxt = fcnt;
    col_nxt  = col;
    if (line_start) begin
      // A marker restarts the line; with a pixel it becomes column 0.
      if (pix_valid) begin
        accept   = 1'b1;
        fcnt_nxt = FCNT_W'(1);
        col_nxt  = COL_W'(1);
      end else begin
        fcnt_nxt = '0;
        col_nxt  = '0;
      end
    end else if (pix_valid) begin
      if (col == COL_W'(LINE_W)) begin
        drop = 1'b1;
      end else begin
        accept  = 1'b1;
        col_nxt = col + COL_W'(1);
        if (fcnt != FCNT_W'(TAPS)) begin
          fcnt_nxt = fcnt + FCNT_W'(1);
        end
      end
    end
    win_done = accept && (fcnt_nxt == FCNT_W'(TAPS));
  end

  // Tap shift register, line counters and sticky overrun flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        taps[i] <= '0;
      end
      fcnt     <= '0;
      col      <= '0;
      tap_full <= 1'b0;
      line_err <= 1'b0;
    end else begin
      if (accept) begin
        for (int i = 0; i < TAPS - 1; i++) begin
          taps[i] <= taps[i+1];
        end
        taps[TAPS-1] <= pix_in;
      end
      fcnt     <= fcnt_nxt;
      col      <= col_nxt;
      tap_full <= win_done;
      if (drop) begin
        line_err <= 1'b1;
      end
    end
  end

  // Stage 1: capture the completed window and its valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        s1_taps[i] <= '0;
      end
    end else begin
      s1_valid <= tap_full;
      for (int i = 0; i < TAPS; i++) begin
        s1_taps[i] <= taps[i];
      end
    end
  end

  cfa_mean4 #(
    .PIX_W (PIX_W)
  ) u_mean4 (
    .a    (s1_taps[0]),
    .b    (s1_taps[1]),
    .c    (s1_taps[CENTRE+1]),
    .d    (s1_taps[CENTRE+2]),
    .mean (mean_w)
  );

  // Stage 2: registered outputs, updated only when a window is emitted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e1        <= '0;
      e2        <= '0;
      e3        <= '0;
      e4        <= '0;
      e5        <= '0;
      mean_1    <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        e1     <= s1_taps[0];
        e2     <= s1_taps[1];
        e3     <= s1_taps[CENTRE];
        e4     <= s1_taps[CENTRE+1];
        e5     <= s1_taps[CENTRE+2];
        mean_1 <= mean_w;
      end
    end
  end

endmodule

// File: tb/tb_cfa_tap_window.sv
// Bench for cfa_tap_window: directed table, corner sequences, random stimulus
// against a line-queue reference model.
module tb_cfa_tap_window;

  localparam int LINE_W = 8;
  localparam int PIX_W  = 12;

  logic             clk;
  logic             rst;
  logic [PIX_W-1:0] pix_in;
  logic             pix_valid;
  logic             line_start;
  logic [PIX_W-1:0] e1, e2, e3, e4, e5, mean_1;
  logic             out_valid;
  logic             line_err;

  int n_vec;
  int n_err;

  cfa_tap_window #(
    .LINE_W (LINE_W),
    .PIX_W  (PIX_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .line_start (line_start),
    .e1         (e1),
    .e2         (e2),
    .e3         (e3),
    .e4         (e4),
    .e5         (e5),
    .mean_1     (mean_1),
    .out_valid  (out_valid),
    .line_err   (line_err)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    bit v;
    int w[5];
  } win_t;

  int   line_q[$];   // accepted pixels of the current line (last 5 kept)
  int   col_m;
  bit   err_m;
  win_t pipe_q[$];   // windows in flight, two edges of latency
  int   held[5];
  bit   ov_m;

  task automatic model_reset();
    win_t z;
    z.v = 1'b0;
    for (int k = 0; k < 5; k++) z.w[k] = 0;
    line_q.delete();
    pipe_q.delete();
    pipe_q.push_back(z);
    pipe_q.push_back(z);
    col_m = 0;
    err_m = 1'b0;
    ov_m  = 1'b0;
    for (int k = 0; k < 5; k++) held[k] = 0;
  endtask

  task automatic model_step(input bit ls, input bit pv, input int pix);
    win_t nw;
    win_t vis;
    nw.v = 1'b0;
    for (int k = 0; k < 5; k++) nw.w[k] = 0;
    if (ls && pv) begin
      line_q.delete();
      line_q.push_back(pix);
      col_m = 1;
    end else if (ls) begin
      line_q.delete();
      col_m = 0;
    end else if (pv) begin
      if (col_m == LINE_W) begin
        err_m = 1'b1;
      end else begin
        line_q.push_back(pix);
        col_m++;
        if (line_q.size() >= 5) begin
          nw.v = 1'b1;
          for (int k = 0; k < 5; k++) nw.w[k] = line_q[line_q.size() - 5 + k];
        end
      end
    end
    while (line_q.size() > 5) void'(line_q.pop_front());
    pipe_q.push_back(nw);
    vis  = pipe_q.pop_front();
    ov_m = vis.v;
    if (vis.v) for (int k = 0; k < 5; k++) held[k] = vis.w[k];
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    chk("m_ov",   int'(out_valid), int'(ov_m));
    chk("m_err",  int'(line_err),  int'(err_m));
    chk("m_e1",   int'(e1), held[0]);
    chk("m_e2",   int'(e2), held[1]);
    chk("m_e3",   int'(e3), held[2]);
    chk("m_e4",   int'(e4), held[3]);
    chk("m_e5",   int'(e5), held[4]);
    chk("m_mean", int'(mean_1), (held[0] + held[1] + held[3] + held[4] + 2) / 4);
  endtask

  // ---------------- drivers ----------------
  // Inputs change at the falling edge; outputs are sampled at the next one.
  task automatic cycle(input bit ls, input bit pv, input int pix);
    line_start = ls;
    pix_valid  = pv;
    pix_in     = PIX_W'(pix);
    @(posedge clk);
    model_step(ls, pv, pix);
    @(negedge clk);
    check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0);
  endtask

  // Reset pulse placed between clock edges.
  task automatic rst_pulse();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_model();
    chk("rst_ov_imm",   int'(out_valid), 0);
    chk("rst_mean_imm", int'(mean_1), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_model();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit ls;
    bit pv;
    int pix;
    bit ov;
    int e[5];
    int mean;
  } vec_t;

  function automatic vec_t mk(input bit ls, input bit pv, input int pix, input bit ov,
                              input int a, input int b, input int c, input int d,
                              input int f, input int mean);
    vec_t v;
    v.ls = ls; v.pv = pv; v.pix = pix; v.ov = ov;
    v.e[0] = a; v.e[1] = b; v.e[2] = c; v.e[3] = d; v.e[4] = f;
    v.mean = mean;
    return v;
  endfunction

  vec_t tbl[17];

  initial begin
    int seen_ov;
    int waited;
    n_vec = 0;
    n_err = 0;

    tbl[0]  = mk(1, 1,   10, 0,  0,  0,  0,  0,  0,  0);
    tbl[1]  = mk(0, 1,   20, 0,  0,  0,  0,  0,  0,  0);
    tbl[2]  = mk(0, 1,   30, 0,  0,  0,  0,  0,  0,  0);
    tbl[3]  = mk(0, 1,   40, 0,  0,  0,  0,  0,  0,  0);
    tbl[4]  = mk(0, 1,   50, 0,  0,  0,  0,  0,  0,  0);
    tbl[5]  = mk(0, 0,    0, 0,  0,  0,  0,  0,  0,  0);
    tbl[6]  = mk(0, 0,    0, 1, 10, 20, 30, 40, 50, 30);
    tbl[7]  = mk(0, 1,   60, 0, 10, 20, 30, 40, 50, 30);
    tbl[8]  = mk(0, 0,    0, 0, 10, 20, 30, 40, 50, 30);
    tbl[9]  = mk(0, 0,    0, 1, 20, 30, 40, 50, 60, 40);
    tbl[10] = mk(1, 1, 4095, 0, 20, 30, 40, 50, 60, 40);
    tbl[11] = mk(0, 1, 4095, 0, 20, 30, 40, 50, 60, 40);
    tbl[12] = mk(0, 1, 4095, 0, 20, 30, 40, 50, 60, 40);
    tbl[13] = mk(0, 1, 4095, 0, 20, 30, 40, 50, 60, 40);
    tbl[14] = mk(0, 1, 4095, 0, 20, 30, 40, 50, 60, 40);
    tbl[15] = mk(0, 0,    0, 0, 20, 30, 40, 50, 60, 40);
    tbl[16] = mk(0, 0,    0, 1, 4095, 4095, 4095, 4095, 4095, 4095);

    // Reset
    rst        = 1'b1;
    pix_in     = '0;
    pix_valid  = 1'b0;
    line_start = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ov",   int'(out_valid), 0);
    chk("reset_err",  int'(line_err), 0);
    chk("reset_e3",   int'(e3), 0);
    chk("reset_mean", int'(mean_1), 0);
    rst = 1'b0;
    idle(2);

    // Directed table: fill, slide, full-scale
    for (int i = 0; i < 17; i++) begin
      cycle(tbl[i].ls, tbl[i].pv, tbl[i].pix);
      chk("tbl_ov",   int'(out_valid), int'(tbl[i].ov));
      chk("tbl_e1",   int'(e1), tbl[i].e[0]);
      chk("tbl_e2",   int'(e2), tbl[i].e[1]);
      chk("tbl_e3",   int'(e3), tbl[i].e[2]);
      chk("tbl_e4",   int'(e4), tbl[i].e[3]);
      chk("tbl_e5",   int'(e5), tbl[i].e[4]);
      chk("tbl_mean", int'(mean_1), tbl[i].mean);
    end

    // Gapped pixels hold, then rounding with taps 1,2,3,2,2
    seen_ov = 0;
    cycle(1, 1, 1); seen_ov += int'(out_valid);
    cycle(0, 0, 0); seen_ov += int'(out_valid);
    cycle(0, 1, 2); seen_ov += int'(out_valid);
    cycle(0, 0, 0); seen_ov += int'(out_valid);
    cycle(0, 1, 3); seen_ov += int'(out_valid);
    cycle(0, 0, 0); seen_ov += int'(out_valid);
    cycle(0, 0, 0); seen_ov += int'(out_valid);
    chk("gap_no_ov", seen_ov, 0);
    cycle(0, 1, 2);
    cycle(0, 1, 2);
    idle(2);
    chk("round_ov",   int'(out_valid), 1);
    chk("round_e1",   int'(e1), 1);
    chk("round_e3",   int'(e3), 3);
    chk("round_mean", int'(mean_1), 2);

    // Line restart: first window must be line B only
    seen_ov = 0;
    cycle(1, 1, 100); seen_ov += int'(out_valid);
    cycle(0, 1, 101); seen_ov += int'(out_valid);
    cycle(0, 1, 102); seen_ov += int'(out_valid);
    cycle(1, 1, 200); seen_ov += int'(out_valid);
    for (int p = 201; p <= 204; p++) begin
      cycle(0, 1, p);
      seen_ov += int'(out_valid);
    end
    chk("lineb_no_early_ov", seen_ov, 0);
    waited = 0;
    while (!out_valid && waited < 10) begin
      idle(1);
      waited++;
    end
    chk("lineb_ov_seen", int'(out_valid), 1);
    chk("lineb_e1", int'(e1), 200);
    chk("lineb_e5", int'(e5), 204);

    // Overrun: 9 pixels into an 8-pixel line
    cycle(1, 1, 1);
    for (int p = 2; p <= 8; p++) cycle(0, 1, p);
    chk("ovr_err_before", int'(line_err), 0);
    cycle(0, 1, 999);
    chk("ovr_err_set", int'(line_err), 1);
    idle(3);
    chk("ovr_e5_last_kept", int'(e5), 8);
    cycle(1, 0, 0);
    idle(1);
    chk("ovr_err_sticky", int'(line_err), 1);

    // Mid-line reset, then five fresh pixels needed
    cycle(1, 1, 50);
    cycle(0, 1, 51);
    cycle(0, 1, 52);
    rst_pulse();
    chk("rst_err_clr", int'(line_err), 0);
    seen_ov = 0;
    for (int p = 7; p <= 10; p++) begin
      cycle(0, 1, p);
      seen_ov += int'(out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      idle(1);
      seen_ov += int'(out_valid);
    end
    chk("rst_no_ov_4pix", seen_ov, 0);
    cycle(0, 1, 11);
    idle(2);
    chk("rst_ov_5pix", int'(out_valid), 1);
    chk("rst_e1",   int'(e1), 7);
    chk("rst_mean", int'(mean_1), 9);

    // Random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst_pulse();
      end else begin
        cycle($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
              int'($urandom_range(0, 4095)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
